seg_p2s_ctrl: RTL and testbench

//  Parallel-to-serial controller feeding the board's external 8-bit segment shift-register chain.
//  - Captures a DATA_WIDTH-bit segment image (8 digits x 8 segments).
//  - Shifts the image out MSB-first on seg_sout/seg_clk, then pulses seg_pen to latch it.
//  - Sits between the display-data mux upstream and the serial shift-register chain downstream.
//  - Upstream handshake is start/busy/done.

---
 rtl/seg_p2s_ctrl_pkg.sv | 19 +
 rtl/p2s_tick_gen.sv | 38 +++
 rtl/seg_p2s_ctrl.sv | 130 +++++++++++++
 tb/tb_seg_p2s_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_p2s_ctrl_pkg.sv
// Shared types and defaults for the segment parallel-to-serial controller.
// The state encoding is fixed: 2'd3 is unused and recovers to idle.
package seg_p2s_ctrl_pkg;

    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefDiv       = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2
    } state_e;

    // Counter width for a count range of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p2s_tick_gen.sv
// Half-period timebase for the serial clock: flags the last cycle of each half-period
// and tracks which half (0 = low, 1 = high) is in progress.
module p2s_tick_gen
    import seg_p2s_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DefDiv
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic phase
);

    localparam int unsigned CW = cnt_width(DIV);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    assign half_tick = (cnt_q == CW'(DIV - 1));
    assign phase     = phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (half_tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seg_p2s_ctrl.sv
// Captures a segment image and shifts it MSB-first into the external shift-register chain,
// then pulses seg_pen to latch it. Upstream handshake is start/busy/done.
module seg_p2s_ctrl
    import seg_p2s_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DIV        = DefDiv
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] par_data,
    output logic                  busy,
    output logic                  done,
    output logic                  seg_clk,
    output logic                  seg_sout,
    output logic                  seg_clrn,
    output logic                  seg_pen
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    logic tick_clr;
    logic half_tick;
    logic phase;
    logic phase_nxt;
    logic accept;
    logic bit_end;
    logic last_bit;

    logic busy_d, done_d, seg_clk_d, seg_sout_d, seg_pen_d;
    logic busy_q, done_q, seg_clk_q, seg_sout_q, seg_pen_q, seg_clrn_q;

    p2s_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (tick_clr),
        .half_tick (half_tick),
        .phase     (phase)
    );

    // The timebase runs only in SHIFT and LATCH so every frame starts on a fresh low half.
    assign tick_clr  = (state_q != StShift) && (state_q != StLatch);
    assign phase_nxt = tick_clr ? 1'b0 : (phase ^ half_tick);
    assign accept    = (state_q == StIdle) && start;
    assign bit_end   = (state_q == StShift) && half_tick && phase;
    assign last_bit  = bit_end && (bit_cnt_q == BCW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StLatch;
            StLatch: if (half_tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shift_d   = par_data;
            bit_cnt_d = BCW'(DATA_WIDTH);
        end else if (bit_end) begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs are decoded from next-state values and registered, so they change on the
    // same edge as the state they describe.
    always_comb begin
        busy_d     = (state_d == StShift) || (state_d == StLatch);
        done_d     = (state_q == StLatch) && (state_d == StIdle);
        seg_clk_d  = (state_d == StShift) && phase_nxt;
        seg_sout_d = (state_d == StShift) && shift_d[DATA_WIDTH-1];
        seg_pen_d  = (state_d == StLatch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_clk_q  <= 1'b0;
            seg_sout_q <= 1'b0;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            seg_clk_q  <= seg_clk_d;
            seg_sout_q <= seg_sout_d;
            seg_pen_q  <= seg_pen_d;
            seg_clrn_q <= 1'b1;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign seg_clk  = seg_clk_q;
    assign seg_sout = seg_sout_q;
    assign seg_pen  = seg_pen_q;
    assign seg_clrn = seg_clrn_q;

endmodule

// File: tb/tb_seg_p2s_ctrl.sv
// Directed bench for seg_p2s_ctrl: a 64-bit/DIV=4 instance and an 8-bit/DIV=1 instance.
module tb_seg_p2s_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start_a;
    logic [63:0] par_a;
    logic        busy_a, done_a, sclk_a, sout_a, clrn_a, pen_a;

    logic        start_b;
    logic [7:0]  par_b;
    logic        busy_b, done_b, sclk_b, sout_b, clrn_b, pen_b;

    seg_p2s_ctrl #(.DATA_WIDTH(64), .DIV(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .par_data(par_a), .busy(busy_a), .done(done_a),
        .seg_clk(sclk_a), .seg_sout(sout_a), .seg_clrn(clrn_a), .seg_pen(pen_a)
    );

    seg_p2s_ctrl #(.DATA_WIDTH(8), .DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .par_data(par_b), .busy(busy_b), .done(done_b),
        .seg_clk(sclk_b), .seg_sout(sout_b), .seg_clrn(clrn_b), .seg_pen(pen_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          m_busy, m_pen, m_rise, m_done, m_done_cyc, m_stab_bad;
    logic [63:0] m_bits;

    // Send one frame on instance A and observe ncyc cycles; optionally pulse start with other
    // data when the busy-cycle count reaches mask1 or mask2.
    task automatic run_a(input logic [63:0] data, input int ncyc, input int mask1,
                         input int mask2);
        int   last_change, last_rise;
        logic prev_clk, prev_sout;
        m_busy = 0; m_pen = 0; m_rise = 0; m_done = 0; m_done_cyc = -1; m_stab_bad = 0;
        m_bits = '0;
        last_change = 0; last_rise = -100;
        @(negedge clk);
        prev_clk = sclk_a; prev_sout = sout_a;
        start_a = 1'b1; par_a = data;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (busy_a) m_busy++;
            if (pen_a) m_pen++;
            if (done_a) begin
                m_done++;
                if (m_done_cyc < 0) m_done_cyc = c;
            end
            if (sout_a !== prev_sout) begin
                if (c - last_rise < 4) m_stab_bad++;
                last_change = c;
            end
            if (sclk_a && !prev_clk) begin
                m_rise++;
                m_bits = {m_bits[62:0], sout_a};
                if (c - last_change < 4) m_stab_bad++;
                last_rise = c;
            end
            prev_clk = sclk_a; prev_sout = sout_a;
            if ((mask1 > 0 && m_busy == mask1) || (mask2 > 0 && m_busy == mask2)) begin
                start_a = 1'b1;
                par_a   = ~data;
            end
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || sclk_a !== 1'b0 || sout_a !== 1'b0 ||
            pen_a !== 1'b0 || clrn_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got busy=%b done=%b clk=%b sout=%b pen=%b clrn=%b want all 0",
                     busy_a, done_a, sclk_a, sout_a, pen_a, clrn_a);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (clrn_a !== 1'b0) begin
            n_bad++;
            $display("FAIL clrn_before_edge: got %b want 0", clrn_a);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (clrn_a !== 1'b1 || clrn_b !== 1'b1) begin
            n_bad++;
            $display("FAIL clrn_after_release: got a=%b b=%b want 1", clrn_a, clrn_b);
        end
    endtask

    task automatic test_basic;
        run_a(64'h8000_0000_0000_0001, 540, 0, 0);
        n_cmp++;
        if (m_bits !== 64'h8000_0000_0000_0001) begin
            n_bad++; $display("FAIL basic_stream: got %h want 8000000000000001", m_bits);
        end
        n_cmp++;
        if (m_rise != 64) begin n_bad++; $display("FAIL basic_rises: got %0d want 64", m_rise); end
        n_cmp++;
        if (m_pen != 4) begin n_bad++; $display("FAIL basic_pen_width: got %0d want 4", m_pen); end
        n_cmp++;
        if (m_busy != 516) begin n_bad++; $display("FAIL basic_busy: got %0d want 516", m_busy); end
        n_cmp++;
        if (m_done_cyc != 517) begin
            n_bad++; $display("FAIL basic_done_latency: got %0d want 517", m_done_cyc);
        end
        n_cmp++;
        if (m_done != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", m_done); end
    endtask

    task automatic test_alternating;
        run_a(64'hAAAA_AAAA_AAAA_AAAA, 530, 0, 0);
        n_cmp++;
        if (m_bits !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            n_bad++; $display("FAIL alt_stream: got %h want aaaaaaaaaaaaaaaa", m_bits);
        end
        n_cmp++;
        if (m_stab_bad != 0) begin
            n_bad++; $display("FAIL alt_sout_stability: got %0d violations want 0", m_stab_bad);
        end
        n_cmp++;
        if (m_rise != 64) begin n_bad++; $display("FAIL alt_rises: got %0d want 64", m_rise); end
    endtask

    task automatic test_busy_mask;
        run_a(64'h0123_4567_89AB_CDEF, 560, 10, 300);
        n_cmp++;
        if (m_bits !== 64'h0123_4567_89AB_CDEF) begin
            n_bad++; $display("FAIL mask_stream: got %h want 0123456789abcdef", m_bits);
        end
        n_cmp++;
        if (m_done != 1) begin n_bad++; $display("FAIL mask_done_count: got %0d want 1", m_done); end
        n_cmp++;
        if (m_busy != 516) begin n_bad++; $display("FAIL mask_busy: got %0d want 516", m_busy); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] fb [3];
        int          fi, dn, gaps, gap_bad, idle_run;
        logic        prev_clk;
        fi = 0; dn = 0; gaps = 0; gap_bad = 0; idle_run = 0;
        for (int i = 0; i < 3; i++) fb[i] = '0;
        @(negedge clk);
        prev_clk = sclk_a;
        start_a = 1'b1; par_a = 64'hFF00_FF00_FF00_FF00;
        for (int c = 1; c <= 2070; c++) begin
            @(negedge clk);
            start_a = (c < 1540);
            if (sclk_a && !prev_clk && fi < 3) fb[fi] = {fb[fi][62:0], sout_a};
            prev_clk = sclk_a;
            if (done_a) begin dn++; fi++; end
            if (!busy_a) begin
                idle_run++;
            end else begin
                if (idle_run > 0) begin
                    gaps++;
                    if (idle_run != 1) gap_bad++;
                end
                idle_run = 0;
            end
        end
        n_cmp++;
        if (dn != 3) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 3", dn); end
        n_cmp++;
        if (gaps != 2 || gap_bad != 0) begin
            n_bad++; $display("FAIL b2b_idle_gaps: got gaps=%0d bad=%0d want gaps=2 bad=0", gaps, gap_bad);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (fb[i] !== 64'hFF00_FF00_FF00_FF00) begin
                n_bad++; $display("FAIL b2b_stream%0d: got %h want ff00ff00ff00ff00", i, fb[i]);
            end
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_final_idle: got busy=%b want 0", busy_a); end
    endtask

    task automatic test_div1;
        int          nb, np, nr, dcyc;
        logic [7:0]  bits;
        logic [15:0] clk_pat;
        logic        prev_clk;
        nb = 0; np = 0; nr = 0; dcyc = -1; bits = '0; clk_pat = '0;
        @(negedge clk);
        prev_clk = sclk_b;
        start_b = 1'b1; par_b = 8'hC3;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (busy_b) nb++;
            if (pen_b) np++;
            if (busy_b && !pen_b) clk_pat = {clk_pat[14:0], sclk_b};
            if (sclk_b && !prev_clk) begin nr++; bits = {bits[6:0], sout_b}; end
            prev_clk = sclk_b;
            if (done_b && dcyc < 0) dcyc = c;
        end
        n_cmp++;
        if (bits !== 8'hC3) begin n_bad++; $display("FAIL div1_stream: got %h want c3", bits); end
        n_cmp++;
        if (nb != 17) begin n_bad++; $display("FAIL div1_busy: got %0d want 17", nb); end
        n_cmp++;
        if (clk_pat !== 16'h5555) begin
            n_bad++; $display("FAIL div1_clk_toggle: got %h want 5555", clk_pat);
        end
        n_cmp++;
        if (np != 1) begin n_bad++; $display("FAIL div1_pen_width: got %0d want 1", np); end
        n_cmp++;
        if (nr != 8 || dcyc != 18) begin
            n_bad++; $display("FAIL div1_rises_done: got rises=%0d done=%0d want 8 and 18", nr, dcyc);
        end
    endtask

    task automatic test_reset_abort;
        int dn, np, nbusy;
        dn = 0; np = 0; nbusy = 0;
        @(negedge clk);
        start_a = 1'b1; par_a = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b1) begin n_bad++; $display("FAIL abort_precond_busy: got %b want 1", busy_a); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || sclk_a !== 1'b0 || sout_a !== 1'b0 ||
            pen_a !== 1'b0 || clrn_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_values: got busy=%b done=%b clk=%b sout=%b pen=%b clrn=%b want all 0",
                     busy_a, done_a, sclk_a, sout_a, pen_a, clrn_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (clrn_a !== 1'b1) begin n_bad++; $display("FAIL abort_clrn: got %b want 1", clrn_a); end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done_a) dn++;
            if (pen_a) np++;
            if (busy_a) nbusy++;
        end
        n_cmp++;
        if (dn != 0 || np != 0 || nbusy != 0) begin
            n_bad++;
            $display("FAIL abort_no_resume: got done=%0d pen=%0d busy=%0d want 0 0 0", dn, np, nbusy);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; par_a = '0;
        start_b = 1'b0; par_b = '0;
        #2;
        test_reset();
        test_basic();
        test_alternating();
        test_busy_mask();
        test_back_to_back();
        test_div1();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
